intra4_mode_select: RTL and testbench

Downstream consumer of the 4x4 intra predictors (DC, TM, VE, HE, …), one candidate at a time. For each candidate it takes the source block and that candidate's predicted block, accumulates a distortion cost row by row, and keeps the lowest-cost candidate. After the candidate flagged last, it emits the winning mode, its cost and its prediction block to the residual/transform stage.

---
 rtl/intra_pkg.sv | 23 ++
 rtl/intra4_row_cost.sv | 40 ++++
 rtl/intra4_mode_select.sv | 138 +++++++++++++
 tb/tb_intra4_mode_select.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/intra_pkg.sv
// Shared definitions for the 4x4 intra blocks: FSM states, pixel layout, cost sizing.
package intra_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, CMP, OUT} state_t;

  localparam int BLOCK_SIZE_DEF = 4;
  localparam int PIX_COUNT      = BLOCK_SIZE_DEF * BLOCK_SIZE_DEF;

  // LSB of pixel (r,c) in a row-major packed block, r=0 is the top row.
  function automatic int pix_lsb(input int r, input int c, input int bw, input int bs);
    return bw * (r * bs + c);
  endfunction

  // Bits needed to hold a worst-case SSE over npix pixels of bw bits.
  function automatic int sse_cost_width(input int bw, input int npix);
    longint max_px;
    longint max_sum;
    max_px  = (longint'(1) << bw) - 1;
    max_sum = longint'(npix) * max_px * max_px;
    return $clog2(max_sum + 1);
  endfunction

endpackage

// File: rtl/intra4_row_cost.sv
// Combinational distortion of one row of pixel pairs: SSE by default,
// SAD when INTRA4_SAD_METRIC_EN is defined.
module intra4_row_cost #(
  parameter int BIT_WIDTH  = 8,
  parameter int BLOCK_SIZE = 4,
  parameter int COST_WIDTH = 20
) (
  input  logic [BIT_WIDTH*BLOCK_SIZE-1:0] src_row,
  input  logic [BIT_WIDTH*BLOCK_SIZE-1:0] pred_row,
  output logic [COST_WIDTH-1:0]           row_cost
);

  logic [COST_WIDTH-1:0] term [BLOCK_SIZE];

  for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_pix
    logic signed [BIT_WIDTH:0] diff;
    logic        [BIT_WIDTH-1:0] mag;

    assign diff = $signed({1'b0, src_row[gi*BIT_WIDTH +: BIT_WIDTH]})
                - $signed({1'b0, pred_row[gi*BIT_WIDTH +: BIT_WIDTH]});
    // |diff| always fits BIT_WIDTH bits, so squaring it gives exactly 2*BIT_WIDTH bits.
    assign mag  = diff[BIT_WIDTH] ? BIT_WIDTH'(-diff) : BIT_WIDTH'(diff);

`ifdef INTRA4_SAD_METRIC_EN
    assign term[gi] = COST_WIDTH'(mag);
`else
    logic [2*BIT_WIDTH-1:0] sq;
    assign sq       = mag * mag;
    assign term[gi] = COST_WIDTH'(sq);
`endif
  end

  always_comb begin
    row_cost = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      row_cost = row_cost + term[i];
    end
  end

endmodule

// File: rtl/intra4_mode_select.sv
// Picks the lowest-cost 4x4 intra candidate of a group and emits its mode, cost and block.
// Cost metric chosen in intra4_row_cost via INTRA4_SAD_METRIC_EN (SAD) or default SSE.
module intra4_mode_select
  import intra_pkg::*;
#(
  parameter int BIT_WIDTH  = 8,
  parameter int BLOCK_SIZE = 4,
  parameter int MODE_WIDTH = 4,
  parameter int COST_WIDTH = 20
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic                                     in_last,
  input  logic [MODE_WIDTH-1:0]                    in_mode,
  input  logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] src,
  input  logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] pred,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [MODE_WIDTH-1:0]                    out_mode,
  output logic [COST_WIDTH-1:0]                    out_cost,
  output logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] out_pred
);

  localparam int BLK_W  = BIT_WIDTH * BLOCK_SIZE * BLOCK_SIZE;
  localparam int ROW_W  = BIT_WIDTH * BLOCK_SIZE;
  localparam int ROW_CW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam logic [ROW_CW-1:0] LAST_ROW = ROW_CW'(BLOCK_SIZE - 1);

  state_t                state_q;
  logic [BLK_W-1:0]      src_q, pred_q, best_pred_q, out_pred_q;
  logic [MODE_WIDTH-1:0] mode_q, best_mode_q, out_mode_q;
  logic [COST_WIDTH-1:0] acc_q, best_cost_q, out_cost_q;
  logic [ROW_CW-1:0]     row_q;
  logic                  last_q, first_q, in_ready_q, out_valid_q;

  logic [ROW_W-1:0]      src_row, pred_row;
  logic [COST_WIDTH-1:0] row_cost, acc_d;
  logic                  take_d;
  int                    row_base;

  always_comb begin
    row_base = pix_lsb(int'(row_q), 0, BIT_WIDTH, BLOCK_SIZE);
    src_row  = src_q[row_base +: ROW_W];
    pred_row = pred_q[row_base +: ROW_W];
    acc_d    = acc_q + row_cost;
    // Strict compare: on a tie the earlier candidate stays best.
    take_d   = first_q || (acc_q < best_cost_q);
  end

  intra4_row_cost #(
    .BIT_WIDTH  (BIT_WIDTH),
    .BLOCK_SIZE (BLOCK_SIZE),
    .COST_WIDTH (COST_WIDTH)
  ) u_row_cost (
    .src_row  (src_row),
    .pred_row (pred_row),
    .row_cost (row_cost)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      src_q       <= '0;
      pred_q      <= '0;
      mode_q      <= '0;
      last_q      <= 1'b0;
      acc_q       <= '0;
      row_q       <= '0;
      first_q     <= 1'b1;
      best_mode_q <= '0;
      best_cost_q <= '0;
      best_pred_q <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_mode_q  <= '0;
      out_cost_q  <= '0;
      out_pred_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            src_q      <= src;
            pred_q     <= pred;
            mode_q     <= in_mode;
            last_q     <= in_last;
            acc_q      <= '0;
            row_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ACCUM;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ACCUM: begin
          acc_q <= acc_d;
          row_q <= row_q + 1'b1;
          if (row_q == LAST_ROW) state_q <= CMP;
        end
        CMP: begin
          first_q <= 1'b0;
          if (take_d) begin
            best_mode_q <= mode_q;
            best_cost_q <= acc_q;
            best_pred_q <= pred_q;
          end
          if (last_q) begin
            out_valid_q <= 1'b1;
            out_mode_q  <= take_d ? mode_q : best_mode_q;
            out_cost_q  <= take_d ? acc_q  : best_cost_q;
            out_pred_q  <= take_d ? pred_q : best_pred_q;
            state_q     <= OUT;
          end else begin
            in_ready_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            first_q     <= 1'b1;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_mode  = out_mode_q;
  assign out_cost  = out_cost_q;
  assign out_pred  = out_pred_q;

endmodule

// File: tb/tb_intra4_mode_select.sv
// Self-checking bench for intra4_mode_select: directed cases plus randomized groups
// checked against a group-level model (queue of candidate costs, first minimum wins).
module tb_intra4_mode_select;
  import intra_pkg::*;

  localparam int BW  = 8;
  localparam int BS  = 4;
  localparam int MW  = 4;
  localparam int CW  = 20;
  localparam int NP  = BS * BS;
  localparam int BLK = BW * NP;

`ifdef INTRA4_SAD_METRIC_EN
  localparam int L_THREE = 16, L_TIE = 32, L_MAX = 4080, L_CHK = 2040, L_AFTER = 160;
`else
  localparam int L_THREE = 16, L_TIE = 64, L_MAX = 1040400, L_CHK = 520200, L_AFTER = 1600;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_last = 1'b0;
  logic           out_ready = 1'b0;
  logic [MW-1:0]  in_mode = '0;
  logic [BLK-1:0] src = '0;
  logic [BLK-1:0] pred = '0;
  logic           in_ready;
  logic           out_valid;
  logic [MW-1:0]  out_mode;
  logic [CW-1:0]  out_cost;
  logic [BLK-1:0] out_pred;

  int n_checks = 0;
  int n_fail   = 0;

  int             q_cost[$];
  int             q_mode[$];
  logic [BLK-1:0] q_pred[$];

  intra4_mode_select #(
    .BIT_WIDTH (BW), .BLOCK_SIZE (BS), .MODE_WIDTH (MW), .COST_WIDTH (CW)
  ) dut (
    .clk (clk), .rst (rst),
    .in_valid (in_valid), .in_ready (in_ready), .in_last (in_last),
    .in_mode (in_mode), .src (src), .pred (pred),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_mode (out_mode), .out_cost (out_cost), .out_pred (out_pred)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [BLK-1:0] act, input logic [BLK-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [BLK-1:0] fill(input int v);
    logic [BLK-1:0] b;
    for (int i = 0; i < NP; i++) b[BW*i +: BW] = BW'(v);
    return b;
  endfunction

  function automatic logic [BLK-1:0] checker_blk();
    logic [BLK-1:0] b;
    for (int r = 0; r < BS; r++)
      for (int c = 0; c < BS; c++)
        b[pix_lsb(r, c, BW, BS) +: BW] = ((r + c) % 2 == 1) ? 8'd255 : 8'd0;
    return b;
  endfunction

  function automatic logic [BLK-1:0] rnd_blk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [BLK-1:0] near_blk(input logic [BLK-1:0] s);
    logic [BLK-1:0] b;
    for (int i = 0; i < NP; i++) begin
      int v;
      v = int'(s[BW*i +: BW]) + int'($urandom_range(0, 6)) - 3;
      if (v < 0) v = 0;
      if (v > 255) v = 255;
      b[BW*i +: BW] = BW'(v);
    end
    return b;
  endfunction

  // Distortion straight from the pixel definition: squared or absolute difference.
  function automatic int model_cost(input logic [BLK-1:0] a, input logic [BLK-1:0] b);
    int sum;
    sum = 0;
    for (int i = 0; i < NP; i++) begin
      int d;
      d = int'(a[BW*i +: BW]) - int'(b[BW*i +: BW]);
`ifdef INTRA4_SAD_METRIC_EN
      sum += (d < 0) ? -d : d;
`else
      sum += d * d;
`endif
    end
    return sum;
  endfunction

  task automatic scramble();
    in_valid  = 1'($urandom());
    in_last   = 1'($urandom());
    in_mode   = MW'($urandom());
    out_ready = 1'($urandom());
    src       = rnd_blk();
    pred      = rnd_blk();
  endtask

  task automatic clear_model();
    q_cost.delete();
    q_mode.delete();
    q_pred.delete();
  endtask

  // Called and returns at a falling edge with the DUT expected idle and ready.
  task automatic run_cand(input logic [BLK-1:0] s, input logic [BLK-1:0] p,
                          input logic [MW-1:0] mode, input bit last, input int hold,
                          input int lit_mode, input int lit_cost);
    int             bi;
    int             e_cost, e_mode;
    logic [BLK-1:0] e_pred;
    chk("accept_in_ready", in_ready, 1);
    src = s; pred = p; in_mode = mode; in_last = last; in_valid = 1'b1; out_ready = 1'b0;
    q_cost.push_back(model_cost(s, p));
    q_mode.push_back(int'(mode));
    q_pred.push_back(p);
    @(posedge clk); #1;
    for (int k = 1; k <= 5; k++) begin
      scramble();
      @(negedge clk);
      chk("busy_in_ready", in_ready, 0);
      chk("busy_out_valid", out_valid, 0);
      if (k < 5) begin
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (!last) begin
      $display("cand mode=%0d cost=%0d last=0", mode, model_cost(s, p));
      chk("next_in_ready", in_ready, 1);
      chk("nonlast_out_valid", out_valid, 0);
    end else begin
      bi = 0;
      for (int i = 1; i < q_cost.size(); i++)
        if (q_cost[i] < q_cost[bi]) bi = i;
      e_cost = q_cost[bi]; e_mode = q_mode[bi]; e_pred = q_pred[bi];
      $display("cand mode=%0d cost=%0d last=1 -> group of %0d best mode=%0d cost=%0d hold=%0d",
               mode, model_cost(s, p), q_cost.size(), e_mode, e_cost, hold);
      chk("out_valid", out_valid, 1);
      chk("out_in_ready", in_ready, 0);
      chk("out_mode", out_mode, e_mode);
      chk("out_cost", out_cost, e_cost);
      chk("out_pred", out_pred, e_pred);
      if (lit_cost >= 0) begin
        chk("lit_mode", out_mode, lit_mode);
        chk("lit_cost", out_cost, lit_cost);
      end
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        scramble();
        out_ready = 1'b0;
        @(negedge clk);
        chk("hold_out_valid", out_valid, 1);
        chk("hold_in_ready", in_ready, 0);
        chk("hold_out_mode", out_mode, e_mode);
        chk("hold_out_cost", out_cost, e_cost);
        chk("hold_out_pred", out_pred, e_pred);
      end
      in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("post_hs_out_valid", out_valid, 0);
      chk("post_hs_in_ready", in_ready, 1);
      clear_model();
    end
  endtask

  // Asserts reset mid-cycle, checks outputs clear at once, returns at a falling edge with in_ready=1.
  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    $display("reset asserted");
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_mode", out_mode, 0);
    chk("rst_out_cost", out_cost, 0);
    chk("rst_out_pred", out_pred, 0);
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_release_in_ready", in_ready, 0);
    @(negedge clk);
    chk("first_edge_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [BLK-1:0] gs, gp, prev_p;
    int             n;

    do_reset();

    run_cand(fill(100), fill(100), 4'd0, 1'b1, 0, 0, 0);

    run_cand(fill(100), fill(98),  4'd0, 1'b0, 0, 0, -1);
    run_cand(fill(100), fill(103), 4'd1, 1'b0, 0, 0, -1);
    run_cand(fill(100), fill(101), 4'd2, 1'b1, 0, 2, L_THREE);

    run_cand(fill(100), fill(102), 4'd3, 1'b0, 0, 0, -1);
    run_cand(fill(100), fill(98),  4'd5, 1'b1, 1, 3, L_TIE);

    run_cand(fill(255), fill(0), 4'd6, 1'b1, 0, 6, L_MAX);
    run_cand(fill(0), checker_blk(), 4'd11, 1'b1, 3, 11, L_CHK);

    // Abort a group during the second candidate's accumulation.
    run_cand(fill(100), fill(100), 4'd7, 1'b0, 0, 0, -1);
    src = fill(0); pred = fill(200); in_mode = 4'd8; in_last = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    do_reset();
    run_cand(fill(50), fill(60), 4'd9, 1'b1, 0, 9, L_AFTER);

    for (int g = 0; g < 30; g++) begin
      n  = int'($urandom_range(1, 4));
      gs = rnd_blk();
      prev_p = rnd_blk();
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 3))
          0:       gp = prev_p;
          1:       gp = rnd_blk();
          default: gp = near_blk(gs);
        endcase
        prev_p = gp;
        run_cand(gs, gp, MW'($urandom()), (k == n - 1), int'($urandom_range(0, 3)), 0, -1);
        if ($urandom_range(0, 3) == 0) begin
          repeat (int'($urandom_range(1, 3))) begin
            @(negedge clk);
            chk("idle_in_ready", in_ready, 1);
          end
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
